// File: rtl/partoserial_framer.sv
// Gapless WIDTH-bit parallel-to-serial framer with valid/ready intake and idle-word fill.
// Define PARTOSERIAL_PARITY_EN to append an even-parity bit to every frame.
module partoserial_framer #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             frame_start,
  output logic             data_valid_out
);

`ifdef PARTOSERIAL_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned      CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {StStart, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             data_out_q, data_out_d;
  logic             frame_start_q, frame_start_d;
  logic             data_valid_q, data_valid_d;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] tx_word;
`ifdef PARTOSERIAL_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign load      = (state_q == StStart) || (bitcnt_q == LAST_IDX);
  assign ready_out = reset & load;

  // tx_word is the loaded word rearranged so its MSB is always the first bit on the wire.
  always_comb begin
    load_word = valid_in ? data_in : IDLE_WORD;
    tx_word   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tx_word[i] = MSB_FIRST ? load_word[i] : load_word[WIDTH-1-i];
    end
  end

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    data_out_d    = data_out_q;
    frame_start_d = 1'b0;
    data_valid_d  = data_valid_q;
`ifdef PARTOSERIAL_PARITY_EN
    parity_d      = parity_q;
`endif
    if (load) begin
      state_d       = StRun;
      bitcnt_d      = '0;
      shreg_d       = tx_word << 1;
      data_out_d    = tx_word[WIDTH-1];
      frame_start_d = 1'b1;
      data_valid_d  = valid_in;
`ifdef PARTOSERIAL_PARITY_EN
      parity_d      = ^load_word;
`endif
    end else begin
      bitcnt_d   = bitcnt_q + 1'b1;
      shreg_d    = shreg_q << 1;
      data_out_d = shreg_q[WIDTH-1];
`ifdef PARTOSERIAL_PARITY_EN
      // Word bits are exhausted; the trailing slot carries the parity bit.
      if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
        data_out_d = parity_q;
      end
`endif
    end
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q       <= StStart;
      bitcnt_q      <= '0;
      shreg_q       <= IDLE_WORD;
      data_out_q    <= 1'b0;
      frame_start_q <= 1'b0;
      data_valid_q  <= 1'b0;
`ifdef PARTOSERIAL_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shreg_q       <= shreg_d;
      data_out_q    <= data_out_d;
      frame_start_q <= frame_start_d;
      data_valid_q  <= data_valid_d;
`ifdef PARTOSERIAL_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign data_out       = data_out_q;
  assign frame_start    = frame_start_q;
  assign data_valid_out = data_valid_q;

endmodule

// File: doc/partoserial_framer.md
Name: partoserial_framer

Overview:
Parametrised successor to the 8-bit parallel-to-serial converter. It converts WIDTH-bit words to a continuous serial bit stream, one bit per clk_8f edge.
- Adds a valid/ready handshake so upstream knows exactly when a word was taken.
- Inserts a programmable idle word whenever no data is offered.
- Marks word boundaries (frame_start) and data-vs-idle bits (data_valid_out).
- Sits between the byte-striping/FIFO stage and the serial link in the PHY transmit path.

Parameters:
- WIDTH, 8, bits per word (2..32).
- IDLE_WORD, 8'hBC (WIDTH bits), word transmitted when no data is accepted (comma/K-like idle).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk_8f, in, 1, bit clock (WIDTH× word rate); all logic on posedge.
- reset, in, 1, asynchronous, active-low; 0 = in reset.
- data_in, in, WIDTH, parallel word offered by upstream.
- valid_in, in, 1, data_in holds a valid word.
- ready_out, out, 1, block takes a word at the next edge; transfer = valid_in && ready_out at posedge.
- data_out, out, 1, serial bit (registered).
- frame_start, out, 1, high while data_out carries the first bit of a frame (registered).
- data_valid_out, out, 1, high while data_out carries a bit of an accepted data word; low for idle or reset (registered).

Behaviour:
- FRAME_LEN = WIDTH; WIDTH+1 with the optional feature.
- States: START (first boundary after reset) and RUN. bitcnt = index (0..FRAME_LEN-1) of the bit currently on data_out. shreg holds the current frame.
- Reset (reset=0, async, any time incl. mid-word):
  - data_out=0, frame_start=0, data_valid_out=0, ready_out=0.
  - bitcnt=0, shreg=IDLE_WORD, state=START.
  - The partial word in flight is discarded and is not retransmitted.
- ready_out (combinational from state): 1 when state==START, or when state==RUN && bitcnt==FRAME_LEN-1. Otherwise 0. Forced 0 while reset=0.
- Load edge (ready_out=1):
  - Word loaded = data_in if valid_in, else IDLE_WORD.
  - data_out <= first bit of that word; frame_start <= 1; data_valid_out <= valid_in.
  - bitcnt <= 0; state <= RUN.
- Non-load edge in RUN:
  - data_out <= next bit in MSB_FIRST order; bitcnt <= bitcnt+1.
  - frame_start <= 0; data_valid_out holds its value.
- Latency: word accepted at edge E drives its first bit after E and its last bit after E+FRAME_LEN-1. The next load occurs at E+FRAME_LEN.
- Stream is gapless: consecutive frames have no bubble. With no data offered the link carries IDLE_WORD back-to-back.
- valid_in while ready_out=0: ignored. Upstream must hold data_in/valid_in until the transfer edge. A word dropped by upstream before the boundary is not sent.
- data_in is sampled only on the load edge. Changes at other times have no effect.
- After reset release, data_out stays 0 until the first edge (START load). That edge accepts a valid word if offered.

Optional Feature:
- Macro: PARTOSERIAL_PARITY_EN.
- Defined: FRAME_LEN = WIDTH+1. After the WIDTH word bits, one even-parity bit (XOR of the WIDTH loaded bits) is sent, for both idle and data frames. data_valid_out stays high through the parity bit of a data frame. ready_out is asserted while the parity bit is on data_out.
- Undefined: FRAME_LEN = WIDTH; no parity bit; no parity logic synthesised.

Test Plan:
1. Reset low 4 cycles, release, valid_in=0 -> data_out=0 during reset. First edge loads idle; stream 1,0,1,1,1,1,0,0 repeating. frame_start every 8th cycle; data_valid_out=0; ready_out pulses 1 cycle in 8.
2. At a ready_out cycle: valid_in=1, data_in=8'hA5 -> next 8 bits 1,0,1,0,0,1,0,1 with data_valid_out=1. valid_in dropped after transfer -> following frame is 8'hBC with data_valid_out=0.
3. valid_in held 1, words 8'h01, 8'hFF, 8'h00, each advanced on its transfer edge -> 24 contiguous bits 00000001 11111111 00000000. Exactly 3 transfers; frame_start at bits 0, 8, 16.
4. valid_in=1, data_in=8'h3C raised at bitcnt=3 of an idle frame -> no transfer until ready_out. Idle frame completes unaltered; 8'h3C sent in the next frame.
5. Reset driven low at bitcnt=3 of 8'hA5 (asynchronous, between edges) -> data_out, frame_start, data_valid_out and ready_out go 0 immediately. After release the stream restarts with a fresh frame; no remnant A5 bits.
6. MSB_FIRST=0, data_in=8'h0F -> 1,1,1,1,0,0,0,0. With PARTOSERIAL_PARITY_EN, MSB_FIRST=1:
   - 8'h07 -> 0,0,0,0,0,1,1,1,1 (9 bits).
   - Idle -> 1,0,1,1,1,1,0,0,1.
   - ready_out every 9th cycle.
